cuasi_arbiter: RTL



---
 rtl/cuasi_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/cuasi_arbiter.sv
// Two-requester round-robin arbiter sequencing shared access to one combinational Cuasi ALU.
// A grant latches the winner's operands, the result is captured one cycle later, then acked for one cycle.
module cuasi_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sel1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_sel,
    input  logic [WIDTH-1:0] alu_C
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   pick1;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        pick1 = 1'b0;
        if (req1 && (!req0 || !last_gnt))
            pick1 = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            result   <= '0;
            alu_A    <= '0;
            alu_B    <= '0;
            alu_sel  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        if (pick1) begin
                            alu_A   <= a1;
                            alu_B   <= b1;
                            alu_sel <= sel1;
                        end else begin
                            alu_A   <= a0;
                            alu_B   <= b0;
                            alu_sel <= sel0;
                        end
                        gnt      <= pick1;
                        last_gnt <= pick1;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_C;
                    ack0   <= ~gnt;
                    ack1   <= gnt;
                    state  <= RESP;
                end
                RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
